// File: rtl/triangle_pkg.sv
// Shared types and helpers for the triangle burst sequencer.
// Imported by the controller and its prescaler.
package triangle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN
  } ctrl_state_t;

  // Enable pulses for one full 0 -> max -> 0 triangle cycle.
  function automatic int steps_per_cycle(input int n);
    return 2 * ((1 << n) - 1);
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step pacing counter: one tick every period_q clocks while running.
// Held at zero while clear is high so the first tick lands period_q cycles in.
module step_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] period_q,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] presc_cnt_q;
  logic [PRESCALE_W-1:0] presc_cnt_d;
  logic                  last;

  assign last = (presc_cnt_q == period_q - PRESCALE_W'(1));
  assign tick = !clear && last;

  always_comb begin
    presc_cnt_d = presc_cnt_q + PRESCALE_W'(1);
    if (clear || last) presc_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) presc_cnt_q <= '0;
    else     presc_cnt_q <= presc_cnt_d;
  end

endmodule

// File: rtl/triangle_burst_controller.sv
// Sequences reset/enable of an N-bit triangle generator in bursts
// of full cycles, or continuously, with graceful stop.
module triangle_burst_controller
  import triangle_pkg::*;
#(
  parameter int N          = 8,
  parameter int PRESCALE_W = 16,
  parameter int BURST_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [PRESCALE_W-1:0] period,
  input  logic [BURST_W-1:0]    bursts,
  output logic                  gen_rst,
  output logic                  gen_ena,
  output logic                  busy,
  output logic                  done,
  output logic [BURST_W-1:0]    cycles_done
);

  localparam logic [N:0] STEP_LAST = (N+1)'(steps_per_cycle(N) - 1);

  ctrl_state_t state_q, state_d;

  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [BURST_W-1:0]    bursts_q, bursts_d;
  logic [BURST_W-1:0]    cycles_q, cycles_d;
  logic [N:0]            step_q, step_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  done_q, done_d;

  logic tick;
  logic wrap;
  logic finish;
  logic presc_clear;

  step_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_presc (
    .clk     (clk),
    .rst     (rst),
    .clear   (presc_clear),
    .period_q(period_q),
    .tick    (tick)
  );

  assign wrap   = (step_q == STEP_LAST);
  assign finish = ((bursts_q != '0) &&
                   (cycles_q + BURST_W'(1) == bursts_q)) ||
                  stop_pend_q || stop;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = CLEAR;
      CLEAR: state_d = RUN;
      RUN:   if (tick && wrap && finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gen_rst     = 1'b0;
    gen_ena     = 1'b0;
    busy        = 1'b1;
    presc_clear = 1'b1;
    unique case (state_q)
      IDLE:  busy = 1'b0;
      CLEAR: gen_rst = 1'b1;
      RUN: begin
        gen_ena     = tick;
        presc_clear = 1'b0;
      end
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    period_d    = period_q;
    bursts_d    = bursts_q;
    cycles_d    = cycles_q;
    step_d      = step_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          period_d    = (period == '0) ? PRESCALE_W'(1) : period;
          bursts_d    = bursts;
          cycles_d    = '0;
          step_d      = '0;
          stop_pend_d = 1'b0;
        end
      end
      CLEAR: if (stop) stop_pend_d = 1'b1;
      RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (tick) begin
          if (wrap) begin
            step_d   = '0;
            cycles_d = cycles_q + BURST_W'(1);
            if (finish) begin
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
            end
          end else begin
            step_d = step_q + (N+1)'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q    <= '0;
      bursts_q    <= '0;
      cycles_q    <= '0;
      step_q      <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      period_q    <= period_d;
      bursts_q    <= bursts_d;
      cycles_q    <= cycles_d;
      step_q      <= step_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  assign done        = done_q;
  assign cycles_done = cycles_q;

endmodule
